// File: rtl/control_unit_if.sv
// Bus between the control unit and the datapath: IR comes in, control strobes go out.
// Step exists only when CU_SINGLE_STEP_EN is defined.
interface control_unit_if;
  logic [15:0] IR;
`ifdef CU_SINGLE_STEP_EN
  logic        Step;
`endif
  logic        PC_clr;
  logic        PC_up;
  logic        IR_ld;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_wr;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  OutState;

  modport master (
`ifdef CU_SINGLE_STEP_EN
    input  Step,
`endif
    input  IR,
    output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
    output RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
  );

  modport slave (
`ifdef CU_SINGLE_STEP_EN
    output Step,
`endif
    output IR,
    input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
    input  RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
  );
endinterface

// File: rtl/control_unit.sv
// Moore fetch/decode/execute sequencer for the 16-bit ISA.
// Optional CU_SINGLE_STEP_EN adds a Wait state released by cu.Step after each instruction.
module control_unit (
  input logic           Clock,
  input logic           Reset,
  control_unit_if.master cu
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_WAIT   = 4'd10
  } state_t;

  state_t state, state_next, done_next;

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_INIT;
    else       state <= state_next;
  end

`ifdef CU_SINGLE_STEP_EN
  assign done_next = S_WAIT;
`else
  assign done_next = S_FETCH;
`endif

  // IR is only consulted from Decode onward; in Fetch it still holds stale contents.
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:   state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (cu.IR[15:12])
          4'h1:    state_next = S_STORE;
          4'h2:    state_next = S_LOAD_A;
          4'h3:    state_next = S_ADD;
          4'h4:    state_next = S_SUB;
          4'h5:    state_next = S_HALT;
          default: state_next = S_NOOP;
        endcase
      end
      S_LOAD_A: state_next = S_LOAD_B;
      S_LOAD_B, S_STORE, S_ADD, S_SUB, S_NOOP: state_next = done_next;
      S_HALT:   state_next = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_WAIT:   state_next = cu.Step ? S_FETCH : S_WAIT;
`else
      S_WAIT:   state_next = S_FETCH;
`endif
      default:  state_next = S_INIT;
    endcase
  end

  always_comb begin
    cu.PC_clr     = 1'b0;
    cu.PC_up      = 1'b0;
    cu.IR_ld      = 1'b0;
    cu.D_addr     = 8'h00;
    cu.D_wr       = 1'b0;
    cu.RF_s       = 1'b0;
    cu.RF_W_addr  = 4'h0;
    cu.RF_W_wr    = 1'b0;
    cu.RF_Ra_addr = 4'h0;
    cu.RF_Rb_addr = 4'h0;
    cu.ALU_s0     = 3'b000;
    cu.OutState   = state;
    case (state)
      S_INIT:  cu.PC_clr = 1'b1;
      S_FETCH: begin
        cu.IR_ld = 1'b1;
        cu.PC_up = 1'b1;
      end
      // Load_B repeats Load_A's addressing while the synchronous RAM returns data.
      S_LOAD_A, S_LOAD_B: begin
        cu.D_addr    = cu.IR[11:4];
        cu.RF_s      = 1'b1;
        cu.RF_W_addr = cu.IR[3:0];
        cu.RF_W_wr   = (state == S_LOAD_B);
      end
      S_STORE: begin
        cu.D_addr     = cu.IR[7:0];
        cu.RF_Ra_addr = cu.IR[11:8];
        cu.D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        cu.RF_Ra_addr = cu.IR[11:8];
        cu.RF_Rb_addr = cu.IR[7:4];
        cu.RF_W_addr  = cu.IR[3:0];
        cu.RF_W_wr    = 1'b1;
        cu.ALU_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, hand sequences for Halt/reset/step,
// then random instruction streams checked against an instruction-level expectation model.
module tb_control_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  control_unit_if bus ();

  control_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .cu    (bus.master)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_wr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } out_t;

  typedef struct {
    logic        rst;
    logic [15:0] ir;
    logic        step;
    out_t        want;
    string       name;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  logic cur_step = 1'b0;
  vec_t table_q[$];

  function automatic out_t mk(input logic [3:0] st, input logic pcc, input logic pcu,
                              input logic irl, input logic [7:0] da, input logic dw,
                              input logic rs, input logic [3:0] wa, input logic ww,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu);
    return '{st, pcc, pcu, irl, da, dw, rs, wa, ww, ra, rb, alu};
  endfunction

  function automatic out_t st_only(input logic [3:0] st);
    return mk(st, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
  endfunction

  function automatic out_t e_init();
    return mk(4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
  endfunction

  function automatic out_t e_fetch();
    return mk(4'd1, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
  endfunction

  // Expected execute-phase outputs for one instruction, phase 0 or 1 (phase 1 only for LOAD).
  function automatic out_t exec_exp(input logic [15:0] ir, input int phase);
    logic [3:0] op;
    op = ir[15:12];
    case (op)
      4'h1: return mk(4'd6, 0, 0, 0, ir[7:0], 1, 0, 4'h0, 0, ir[11:8], 4'h0, 3'b000);
      4'h2: return mk((phase == 0) ? 4'd4 : 4'd5, 0, 0, 0, ir[11:4], 0, 1, ir[3:0],
                      (phase == 1), 4'h0, 4'h0, 3'b000);
      4'h3: return mk(4'd7, 0, 0, 0, 8'h00, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 3'b001);
      4'h4: return mk(4'd8, 0, 0, 0, 8'h00, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 3'b010);
      4'h5: return st_only(4'd9);
      default: return st_only(4'd3);
    endcase
  endfunction

  task automatic check(input string name, input out_t want);
    out_t got;
    got = {bus.OutState, bus.PC_clr, bus.PC_up, bus.IR_ld, bus.D_addr, bus.D_wr, bus.RF_s,
           bus.RF_W_addr, bus.RF_W_wr, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_s0};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s step=%0b: got state=%0d outs=%h, expected state=%0d outs=%h",
               name, cur_step, got.state, got, want.state, want);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check just after.
  task automatic cyc(input logic r, input logic [15:0] ir, input logic s,
                     input out_t want, input string name);
    @(negedge Clock);
    Reset    = r;
    bus.IR   = ir;
    cur_step = s;
`ifdef CU_SINGLE_STEP_EN
    bus.Step = s;
`endif
    #1 check(name, want);
  endtask

  task automatic add(input logic r, input logic [15:0] ir, input out_t want, input string name);
    vec_t v;
    v.rst = r; v.ir = ir; v.step = 1'b1; v.want = want; v.name = name;
    table_q.push_back(v);
  endtask

  task automatic add_done(input logic [15:0] ir);
`ifdef CU_SINGLE_STEP_EN
    add(0, ir, st_only(4'd10), "wait");
`else
    if (ir == 16'hFFFF) add(0, ir, e_fetch(), "unused");
`endif
  endtask

  // Instruction-level model: Fetch, Decode, execute phase(s), optional step wait.
  task automatic run_instr(input logic [15:0] ir);
    int n;
    cyc(0, 16'($urandom), 1'($urandom), e_fetch(), "rnd_fetch");
    cyc(0, ir, 1'($urandom), st_only(4'd2), "rnd_decode");
    n = (ir[15:12] == 4'h2) ? 2 : 1;
    for (int p = 0; p < n; p++) cyc(0, ir, 1'($urandom), exec_exp(ir, p), "rnd_exec");
    if (ir[15:12] == 4'h5) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) cyc(0, 16'($urandom), 1'($urandom), st_only(4'd9), "rnd_halt");
      cyc(1, 16'($urandom), 0, st_only(4'd9), "rnd_halt_rst");
      cyc(0, 16'($urandom), 0, e_init(), "rnd_init");
    end else begin
`ifdef CU_SINGLE_STEP_EN
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) cyc(0, ir, 0, st_only(4'd10), "rnd_wait");
      cyc(0, ir, 1, st_only(4'd10), "rnd_wait_go");
`endif
    end
  endtask

  initial begin
    bus.IR = 16'h0000;
`ifdef CU_SINGLE_STEP_EN
    bus.Step = 1'b0;
`endif
    // Directed test-plan sequence
    add(1, 16'h0000, e_init(), "reset_held");
    add(0, 16'h0000, e_init(), "init");
    add(0, 16'hFFFF, e_fetch(), "fetch1");
    add(0, 16'h2A53, st_only(4'd2), "decode_load");
    add(0, 16'h2A53, mk(4'd4, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'b000), "load_a");
    add(0, 16'h2A53, mk(4'd5, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'b000), "load_b");
    add_done(16'h2A53);
    add(0, 16'hFFFF, e_fetch(), "fetch2");
    add(0, 16'h1B42, st_only(4'd2), "decode_store");
    add(0, 16'h1B42, mk(4'd6, 0, 0, 0, 8'h42, 1, 0, 4'h0, 0, 4'hB, 4'h0, 3'b000), "store");
    add_done(16'h1B42);
    add(0, 16'hFFFF, e_fetch(), "fetch3");
    add(0, 16'h3123, st_only(4'd2), "decode_add");
    add(0, 16'h3123, mk(4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h3, 1, 4'h1, 4'h2, 3'b001), "add");
    add_done(16'h3123);
    add(0, 16'hFFFF, e_fetch(), "fetch4");
    add(0, 16'h4456, st_only(4'd2), "decode_sub");
    add(0, 16'h4456, mk(4'd8, 0, 0, 0, 8'h00, 0, 0, 4'h6, 1, 4'h4, 4'h5, 3'b010), "sub");
    add_done(16'h4456);
    add(0, 16'hFFFF, e_fetch(), "fetch5");
    add(0, 16'hF000, st_only(4'd2), "decode_f000");
    add(0, 16'hF000, st_only(4'd3), "noop_f000");
    add_done(16'hF000);
    add(0, 16'hFFFF, e_fetch(), "fetch6");
    add(0, 16'h5000, st_only(4'd2), "decode_halt");
    add(0, 16'h5000, st_only(4'd9), "halt");

    repeat (2) @(posedge Clock);
    foreach (table_q[i]) cyc(table_q[i].rst, table_q[i].ir, table_q[i].step, table_q[i].want,
                             table_q[i].name);

    // Halt holds for 10 cycles, then reset pulls it back to Init
    for (int k = 0; k < 10; k++) cyc(0, 16'h5000, 1, st_only(4'd9), "halt_hold");
    cyc(1, 16'h5000, 0, st_only(4'd9), "halt_rst_edge");
    cyc(0, 16'h5000, 0, e_init(), "halt_to_init");

    // Reset mid-instruction from Load_A
    cyc(0, 16'hFFFF, 0, e_fetch(), "mid_fetch");
    cyc(0, 16'h2A53, 0, st_only(4'd2), "mid_decode");
    cyc(1, 16'h2A53, 0, mk(4'd4, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'b000), "mid_load_a");
    cyc(0, 16'h2A53, 0, e_init(), "mid_to_init");

`ifdef CU_SINGLE_STEP_EN
    cyc(0, 16'hFFFF, 0, e_fetch(), "ss_fetch");
    cyc(0, 16'h3123, 0, st_only(4'd2), "ss_decode");
    cyc(0, 16'h3123, 0, mk(4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h3, 1, 4'h1, 4'h2, 3'b001), "ss_add");
    for (int k = 0; k < 5; k++) cyc(0, 16'h3123, 0, st_only(4'd10), "ss_wait");
    cyc(0, 16'h3123, 1, st_only(4'd10), "ss_wait_go");
`endif

    // Random instruction stream
    for (int i = 0; i < 80; i++) run_instr(16'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
